axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
- Two-requester AXI-Stream arbiter that shares one downstream channel between two packet sources, for example two header/payload producers feeding one header-insert pipeline.
- Arbitrates at packet granularity with round-robin priority. Once a port is granted, it holds the channel until the beat carrying last completes.
- The output is combinational from the granted input. The downstream consumer is the team's registered skid-buffer stage, which provides timing isolation.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- DATA_BYTE_WIDTH, DATA_WIDTH/8, keep bus width (one bit per byte).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- valid_in_0  input  1  port 0 beat valid.
- data_in_0  input  DATA_WIDTH  port 0 data.
- keep_in_0  input  DATA_BYTE_WIDTH  port 0 byte keep.
- last_in_0  input  1  port 0 final beat of packet.
- ready_out_0  output  1  port 0 ready (combinational).
- valid_in_1, data_in_1, keep_in_1, last_in_1, ready_out_1: same as port 0, for port 1.
- valid_out  output  1  downstream beat valid.
- data_out  output  DATA_WIDTH  downstream data.
- keep_out  output  DATA_BYTE_WIDTH  downstream keep.
- last_out  output  1  downstream last.
- ready_in  input  1  downstream ready.
- grant_id_out  output  1  index of the granted port (registered); meaningful when busy_out=1.
- busy_out  output  1  registered; 1 while a packet grant is held.

Behaviour:
- State: FSM IDLE/BUSY; grant register g; round-robin pointer rr_ptr (the preferred port).
- Reset (rst=1 at a clock edge): FSM=IDLE, g=0, rr_ptr=0.
- Outputs in IDLE: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_out_0=ready_out_1=0, busy_out=0, grant_id_out=0. The first outputs follow this after reset.
- IDLE -> BUSY:
  - if valid_in[rr_ptr]=1, g<=rr_ptr;
  - else if valid_in[~rr_ptr]=1, g<=~rr_ptr;
  - if neither is valid, stay in IDLE.
  - No beat transfers in the IDLE cycle, so arbitration latency is 1 cycle from valid to first possible transfer.
- In BUSY:
  - valid_out=valid_in[g]; data_out/keep_out/last_out = port g fields.
  - ready_out[g]=ready_in; ready_out[~g]=0.
  - busy_out=1; grant_id_out=g.
- Transfer: a beat transfers when valid_out & ready_in.
- BUSY -> IDLE: on a transfer with last_out=1; at the same edge rr_ptr<=~g. Every packet boundary costs exactly one IDLE bubble cycle, so back-to-back packets are never merged.
- Both ports valid in IDLE: the rr_ptr port wins. After its packet, the other port wins the next arbitration if it is still valid.
- Non-granted port:
  - held off indefinitely (ready_out=0) until the current packet's last beat;
  - its valid and data may toggle freely without effect.
- Granted port deasserts valid mid-packet: stay BUSY with valid_out=0; no timeout, no re-arbitration.
- Single-beat packet (last on the first beat): BUSY for exactly 1 cycle if ready_in=1.
- ready_in=0 while BUSY: all granted-port signals are passed through unchanged; the AXI-Stream rule (valid and data held until ready) is the source's duty. The arbiter adds no storage.
- Reset mid-packet: the grant drops next cycle. The remainder of the in-flight packet is subsequently arbitrated as a new packet, so upstream resets are required to be coincident.
- keep and data are passed bit-exact; no width conversion.

Test Plan:
- Reset, then valid_in_0=1 for a 3-beat packet (data 0x11,0x22,0x33, last on 0x33), ready_in=1 -> busy_out rises 1 cycle after valid; beats appear on consecutive cycles; grant_id_out=0; busy_out=0 the cycle after 0x33.
- Both ports continuously valid with 2-beat packets (port 0 data 0xA*, port 1 data 0xB*), ready_in=1 -> output order A,A,B,B,A,A,… with exactly one valid_out=0 bubble between packets; ready_out of the non-granted port is never 1.
- Port 1 alone valid after reset (rr_ptr=0) -> grant_id_out=1. Port 0 then becomes valid mid-packet -> port 0 is not granted until port 1's last beat transfers, then is granted after one IDLE cycle.
- Backpressure: ready_in toggles 1,0,0,1 during a 4-beat packet -> each beat is counted exactly once, last_out aligns with beat 4, and ready_out_g mirrors ready_in every cycle.
- Granted source drops valid for 3 cycles mid-packet -> valid_out=0 for those cycles, busy_out stays 1, and the other port stays blocked.
- rst asserted during beat 2 of a port 0 packet -> next cycle busy_out=0, valid_out=0, rr_ptr=0; after release, arbitration restarts normally.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// Two-port AXI-Stream arbiter: packet-granular round-robin with a one-cycle
// IDLE bubble between packets. The datapath is a combinational mux from the granted port.
module axis_packet_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       valid_in_0,
    input  logic [DATA_WIDTH-1:0]      data_in_0,
    input  logic [DATA_BYTE_WIDTH-1:0] keep_in_0,
    input  logic                       last_in_0,
    output logic                       ready_out_0,

    input  logic                       valid_in_1,
    input  logic [DATA_WIDTH-1:0]      data_in_1,
    input  logic [DATA_BYTE_WIDTH-1:0] keep_in_1,
    input  logic                       last_in_1,
    output logic                       ready_out_1,

    output logic                       valid_out,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [DATA_BYTE_WIDTH-1:0] keep_out,
    output logic                       last_out,
    input  logic                       ready_in,

    output logic                       grant_id_out,
    output logic                       busy_out
);

    // state | meaning
    // IDLE  | no grant held; arbitrate among valid ports, no beat transfers
    // BUSY  | port g owns the channel until its last beat transfers
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    logic   g;
    logic   rr_ptr;

    logic [1:0]                 valid_vec;
    logic                       sel_valid;
    logic [DATA_WIDTH-1:0]      sel_data;
    logic [DATA_BYTE_WIDTH-1:0] sel_keep;
    logic                       sel_last;
    logic                       in_busy;
    logic                       end_pkt;

    assign valid_vec = {valid_in_1, valid_in_0};
    assign in_busy   = (state == BUSY);

    always_comb begin
        sel_valid = valid_in_0;
        sel_data  = data_in_0;
        sel_keep  = keep_in_0;
        sel_last  = last_in_0;
        if (g) begin
            sel_valid = valid_in_1;
            sel_data  = data_in_1;
            sel_keep  = keep_in_1;
            sel_last  = last_in_1;
        end
    end

    // Outputs are forced to zero while IDLE so no stale beat leaks downstream.
    assign valid_out   = in_busy & sel_valid;
    assign data_out    = in_busy ? sel_data : '0;
    assign keep_out    = in_busy ? sel_keep : '0;
    assign last_out    = in_busy & sel_last;
    assign ready_out_0 = in_busy & ~g & ready_in;
    assign ready_out_1 = in_busy &  g & ready_in;

    assign end_pkt = valid_out & ready_in & last_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            g            <= 1'b0;
            rr_ptr       <= 1'b0;
            busy_out     <= 1'b0;
            grant_id_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_vec[rr_ptr]) begin
                        state        <= BUSY;
                        g            <= rr_ptr;
                        busy_out     <= 1'b1;
                        grant_id_out <= rr_ptr;
                    end else if (valid_vec[~rr_ptr]) begin
                        state        <= BUSY;
                        g            <= ~rr_ptr;
                        busy_out     <= 1'b1;
                        grant_id_out <= ~rr_ptr;
                    end
                end
                BUSY: begin
                    if (end_pkt) begin
                        state        <= IDLE;
                        rr_ptr       <= ~g;
                        busy_out     <= 1'b0;
                        grant_id_out <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: directed vector table, reset/single-beat
// sequence, then randomized traffic against a packet-level ownership model.
module tb_axis_packet_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in_0, last_in_0, valid_in_1, last_in_1;
    logic [31:0] data_in_0, data_in_1;
    logic [3:0]  keep_in_0, keep_in_1;
    logic        ready_out_0, ready_out_1;
    logic        valid_out, last_out, ready_in;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        grant_id_out, busy_out;

    int errors = 0;
    int checks = 0;

    axis_packet_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .valid_in_0(valid_in_0), .data_in_0(data_in_0), .keep_in_0(keep_in_0),
        .last_in_0(last_in_0), .ready_out_0(ready_out_0),
        .valid_in_1(valid_in_1), .data_in_1(data_in_1), .keep_in_1(keep_in_1),
        .last_in_1(last_in_1), .ready_out_1(ready_out_1),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
        .last_out(last_out), .ready_in(ready_in),
        .grant_id_out(grant_id_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       rdy;
        logic       vo;
        logic [7:0] dout;
        logic       lo;
        logic       r0;
        logic       r1;
        logic       busy;
        logic       gid;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic v0, logic [7:0] d0, logic l0,
                                logic v1, logic [7:0] d1, logic l1, logic rdy,
                                logic vo, logic [7:0] dout, logic lo,
                                logic r0, logic r1, logic busy, logic gid);
        vec_t t;
        t.v0 = v0; t.d0 = d0; t.l0 = l0; t.v1 = v1; t.d1 = d1; t.l1 = l1;
        t.rdy = rdy; t.vo = vo; t.dout = dout; t.lo = lo; t.r0 = r0;
        t.r1 = r1; t.busy = busy; t.gid = gid;
        return t;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp(string tag, logic e_vo, logic [31:0] e_do, logic [3:0] e_ko,
                       logic e_lo, logic e_r0, logic e_r1, logic e_busy, logic e_gid);
        check({tag, ".valid_out"},    {31'd0, valid_out},    {31'd0, e_vo});
        check({tag, ".data_out"},     data_out,              e_do);
        check({tag, ".keep_out"},     {28'd0, keep_out},     {28'd0, e_ko});
        check({tag, ".last_out"},     {31'd0, last_out},     {31'd0, e_lo});
        check({tag, ".ready_out_0"},  {31'd0, ready_out_0},  {31'd0, e_r0});
        check({tag, ".ready_out_1"},  {31'd0, ready_out_1},  {31'd0, e_r1});
        check({tag, ".busy_out"},     {31'd0, busy_out},     {31'd0, e_busy});
        check({tag, ".grant_id_out"}, {31'd0, grant_id_out}, {31'd0, e_gid});
    endtask

    task automatic drive(logic r, logic a_v0, logic [31:0] a_d0, logic [3:0] a_k0, logic a_l0,
                         logic a_v1, logic [31:0] a_d1, logic [3:0] a_k1, logic a_l1,
                         logic a_rdy);
        rst = r;
        valid_in_0 = a_v0; data_in_0 = a_d0; keep_in_0 = a_k0; last_in_0 = a_l0;
        valid_in_1 = a_v1; data_in_1 = a_d1; keep_in_1 = a_k1; last_in_1 = a_l1;
        ready_in = a_rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: which port owns the channel (-1 = none) and which is preferred.
    int          owner;
    int          pref;
    logic        m_v[2];
    logic [31:0] m_d[2];
    logic [3:0]  m_k[2];
    logic        m_l[2];
    logic        m_rdy;
    logic        m_rst;

    initial begin
        // rows: inputs during the cycle, expected outputs during the same cycle
        tbl[0]  = mk(1, 8'h11, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8'h11, 0, 0, 8'h00, 0, 1,  1, 8'h11, 0, 1, 0, 1, 0);
        tbl[2]  = mk(1, 8'h22, 0, 0, 8'h00, 0, 1,  1, 8'h22, 0, 1, 0, 1, 0);
        tbl[3]  = mk(1, 8'h33, 1, 0, 8'h00, 0, 1,  1, 8'h33, 1, 1, 0, 1, 0);
        tbl[4]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 8'hA1, 0, 1, 8'hB1, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 8'hA1, 0, 1, 8'hB1, 0, 1,  1, 8'hB1, 0, 0, 1, 1, 1);
        tbl[7]  = mk(1, 8'hA1, 0, 1, 8'hB2, 1, 1,  1, 8'hB2, 1, 0, 1, 1, 1);
        tbl[8]  = mk(1, 8'hA1, 0, 1, 8'hB1, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 8'hA1, 0, 1, 8'hB1, 0, 1,  1, 8'hA1, 0, 1, 0, 1, 0);
        tbl[10] = mk(1, 8'hA2, 1, 1, 8'hB1, 0, 1,  1, 8'hA2, 1, 1, 0, 1, 0);
        tbl[11] = mk(1, 8'hA1, 0, 1, 8'hB1, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 8'hA1, 0, 1, 8'hB1, 0, 0,  1, 8'hB1, 0, 0, 0, 1, 1);
        tbl[13] = mk(1, 8'hA1, 0, 1, 8'hB1, 0, 1,  1, 8'hB1, 0, 0, 1, 1, 1);
        tbl[14] = mk(1, 8'hA1, 0, 0, 8'hB2, 1, 1,  0, 8'hB2, 1, 0, 1, 1, 1);
        tbl[15] = mk(1, 8'hA1, 0, 1, 8'hB2, 1, 1,  1, 8'hB2, 1, 0, 1, 1, 1);
        tbl[16] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(0, tbl[i].v0, {24'd0, tbl[i].d0}, 4'hF, tbl[i].l0,
                  tbl[i].v1, {24'd0, tbl[i].d1}, 4'h3, tbl[i].l1, tbl[i].rdy);
            #1;
            cmp($sformatf("vec%0d", i), tbl[i].vo, {24'd0, tbl[i].dout},
                tbl[i].busy ? (tbl[i].gid ? 4'h3 : 4'hF) : 4'h0,
                tbl[i].lo, tbl[i].r0, tbl[i].r1, tbl[i].busy, tbl[i].gid);
            tick();
        end

        // single-beat packet, then reset mid-packet with the pointer left at port 1
        drive(0, 1, 32'h55, 4'hF, 1, 0, 0, 0, 0, 1); #1;
        cmp("sb_idle", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        #1; cmp("sb_beat", 1, 32'h55, 4'hF, 1, 1, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        cmp("sb_after", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 32'h66, 4'hF, 0, 0, 0, 0, 0, 1); #1;
        cmp("rs_idle", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        #1; cmp("rs_beat1", 1, 32'h66, 4'hF, 0, 1, 0, 1, 0); tick();
        drive(1, 1, 32'h77, 4'hF, 0, 0, 0, 0, 0, 1); #1;
        cmp("rs_beat2", 1, 32'h77, 4'hF, 0, 1, 0, 1, 0); tick();
        drive(0, 1, 32'h77, 4'hF, 0, 1, 32'h99, 4'h3, 0, 1); #1;
        cmp("rs_post", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        #1; cmp("rs_regrant", 1, 32'h77, 4'hF, 0, 1, 0, 1, 0); tick();

        owner = 0;
        pref  = 0;

        for (int n = 0; n < 3000; n++) begin
            m_rst = ($urandom_range(0, 99) == 0);
            m_rdy = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < 2; p++) begin
                m_v[p] = ($urandom_range(0, 9) < 6);
                m_d[p] = $urandom;
                m_k[p] = 4'($urandom_range(0, 15));
                m_l[p] = ($urandom_range(0, 3) == 0);
            end
            drive(m_rst, m_v[0], m_d[0], m_k[0], m_l[0], m_v[1], m_d[1], m_k[1], m_l[1], m_rdy);
            #1;
            if (owner < 0)
                cmp("rnd", 0, 0, 0, 0, 0, 0, 0, 0);
            else
                cmp("rnd", m_v[owner], m_d[owner], m_k[owner], m_l[owner],
                    owner == 0 && m_rdy, owner == 1 && m_rdy, 1, owner[0]);
            if (m_rst) begin
                owner = -1;
                pref  = 0;
            end else if (owner < 0) begin
                if (m_v[pref])          owner = pref;
                else if (m_v[1 - pref]) owner = 1 - pref;
            end else if (m_v[owner] && m_rdy && m_l[owner]) begin
                pref  = 1 - owner;
                owner = -1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
